// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module      : music_pkg
// Description : Shared types and helpers for the tone-playback stage:
//               FSM state encoding, millisecond prescaler sizing and the
//               period value below which a note is treated as a rest.
// Revision    : 1.0 - initial release
// ============================================================================
package music_pkg;

  // Playback FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Periods shorter than this cannot form a square wave and are played as silence
  localparam int unsigned REST_CYC = 2;

  // Clock cycles per millisecond
  function automatic int unsigned ms_cyc(input int unsigned clk_fre);
    return clk_fre / 1000;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/music_ms_tick.sv
`default_nettype none
// ============================================================================
// Module      : music_ms_tick
// Description : Millisecond prescaler. Counts 0..MS_CYC-1 while enabled and
//               raises a one-cycle tick on the wrap cycle. A synchronous
//               clear restarts the count so a new note begins on a fresh ms.
// Revision    : 1.0 - initial release
// ============================================================================
module music_ms_tick
  import music_pkg::*;
#(
  parameter int unsigned MS_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = cnt_w(MS_CYC);
  localparam logic [CW-1:0] LAST = CW'(MS_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next prescaler value: clear wins, otherwise wrap at LAST while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/music_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : music_tone_gen
// Description : Plays one note per valid/ready handshake as a 50%-duty square
//               wave for note_dur_ms milliseconds, follows it with a silent
//               GAP_MS articulation gap and pulses note_done on return to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module music_tone_gen
  import music_pkg::*;
#(
  parameter int unsigned CLK_FRE = 50_000_000,
  parameter int unsigned CYCLE_W = 20,
  parameter int unsigned DUR_W   = 16,
  parameter int unsigned GAP_MS  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [CYCLE_W-1:0] note_cycle,
  input  logic [DUR_W-1:0]   note_dur_ms,
  output logic               buzzer,
  output logic               busy,
  output logic               note_done
);

  localparam int unsigned        MS_CYC   = ms_cyc(CLK_FRE);
  localparam logic [DUR_W-1:0]   GAP_LD   = DUR_W'(GAP_MS);
  localparam logic [CYCLE_W-1:0] REST_LIM = CYCLE_W'(REST_CYC);
  localparam bit                 HAS_GAP  = (GAP_MS != 0);

  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] cyc_q, cyc_d;
  logic [CYCLE_W-1:0] per_q, per_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               buzzer_q, buzzer_d;
  logic               done_q, done_d;

  logic accept;
  logic tick;
  logic last_tick;
  logic tone;

  // note_ready depends only on state, so the handshake is a plain AND here
  assign accept    = note_valid && (state_q == ST_IDLE);
  assign tone      = (cyc_q >= REST_LIM);
  // The remaining-ms counter doubles as the gap counter; 1 means final tick
  assign last_tick = tick && (dur_q == DUR_W'(1));

  music_ms_tick #(
    .MS_CYC (MS_CYC)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and completion pulse
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (note_dur_ms != '0) begin
            state_d = ST_PLAY;
          end else if (HAS_GAP) begin
            state_d = ST_GAP;
          end else begin
            // Zero-length note with no gap completes immediately
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (last_tick) begin
          if (HAS_GAP) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (last_tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM status outputs
  always_comb begin
    note_ready = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
  end

  // Datapath: latch note, run period and duration counters, form next buzzer
  always_comb begin
    cyc_d    = cyc_q;
    per_d    = per_q;
    dur_d    = dur_q;
    buzzer_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cyc_d    = note_cycle;
          per_d    = '0;
          // A zero-length note goes straight to the gap, so preload its count
          dur_d    = (note_dur_ms != '0) ? note_dur_ms : GAP_LD;
          // Period counter starts at 0, which is always in the high half
          buzzer_d = (note_dur_ms != '0) && (note_cycle >= REST_LIM);
        end
      end
      ST_PLAY: begin
        if (tick) begin
          dur_d = last_tick ? GAP_LD : dur_q - DUR_W'(1);
        end
        if (tone) begin
          per_d = (per_q == cyc_q - CYCLE_W'(1)) ? '0 : per_q + CYCLE_W'(1);
        end
        // High for the first cycle>>1 counts; odd periods get the longer low half
        buzzer_d = !last_tick && tone && (per_d < (cyc_q >> 1));
      end
      ST_GAP: begin
        if (tick) begin
          dur_d = dur_q - DUR_W'(1);
        end
      end
      default: begin
        buzzer_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q    <= '0;
      per_q    <= '0;
      dur_q    <= '0;
      buzzer_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      per_q    <= per_d;
      dur_q    <= dur_d;
      buzzer_q <= buzzer_d;
      done_q   <= done_d;
    end
  end

  assign buzzer    = buzzer_q;
  assign note_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_music_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_music_tone_gen
// Description : Self-checking bench for music_tone_gen. One instance runs with
//               a 1 ms gap, a second with no gap. Each note is checked cycle by
//               cycle against a timeline computed from duration, gap and period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_music_tone_gen;

  localparam int unsigned CLK_FRE = 100_000;
  localparam int          MS      = 100;

  logic        clk = 1'b0;
  logic        rst;

  logic        nv,  rdy,  bz,  bsy,  dn;
  logic [19:0] nc;
  logic [15:0] nd;

  logic        nv0, rdy0, bz0, bsy0, dn0;
  logic [19:0] nc0;
  logic [15:0] nd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  music_tone_gen #(
    .CLK_FRE (CLK_FRE), .CYCLE_W (20), .DUR_W (16), .GAP_MS (1)
  ) dut (
    .clk (clk), .rst (rst),
    .note_valid (nv), .note_ready (rdy), .note_cycle (nc), .note_dur_ms (nd),
    .buzzer (bz), .busy (bsy), .note_done (dn)
  );

  music_tone_gen #(
    .CLK_FRE (CLK_FRE), .CYCLE_W (20), .DUR_W (16), .GAP_MS (0)
  ) dut_g0 (
    .clk (clk), .rst (rst),
    .note_valid (nv0), .note_ready (rdy0), .note_cycle (nc0), .note_dur_ms (nd0),
    .buzzer (bz0), .busy (bsy0), .note_done (dn0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {buzzer, busy, note_done, note_ready} in cycle k after the accepting edge
  function automatic logic [3:0] model(input int cyc, input int dur, input int gap, input int k);
    int  play  = dur * MS;
    int  total = (dur + gap) * MS;
    logic b    = 1'b0;
    if (k <= play && cyc >= 2) begin
      b = ((k - 1) % cyc) < (cyc / 2);
    end
    return {b, (k <= total), (k == total + 1), (k == total + 1)};
  endfunction

  // Precondition: DUT idle and valid note on the inputs; the next edge accepts it.
  // Checks cycles 1..kstop (or through the done cycle when kstop is 0).
  task automatic run_note(input bit sel, input int cyc, input int dur, input int kstop,
                          input bit nxt, input int ncyc, input int ndur);
    int gap   = sel ? 0 : 1;
    int total = (dur + gap) * MS;
    int last  = (kstop > 0) ? kstop : total + 1;
    logic [3:0] got;
    @(posedge clk);
    #1;
    // Present the following note (or garbage with valid low); must not disturb this one
    if (sel) begin
      nv0 = nxt;
      nc0 = nxt ? 20'(ncyc) : 20'($urandom);
      nd0 = nxt ? 16'(ndur) : 16'($urandom);
    end else begin
      nv  = nxt;
      nc  = nxt ? 20'(ncyc) : 20'($urandom);
      nd  = nxt ? 16'(ndur) : 16'($urandom);
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      got = sel ? {bz0, bsy0, dn0, rdy0} : {bz, bsy, dn, rdy};
      check($sformatf("g%0d_c%0d_d%0d_k%0d", gap, cyc, dur, k), 32'(got),
            32'(model(cyc, dur, gap, k)));
    end
  endtask

  initial begin
    int c, d, c2, d2;
    bit b2b;
    rst = 1'b1;
    nv  = 1'b1; nc  = 20'd10; nd  = 16'd2;
    nv0 = 1'b0; nc0 = '0;     nd0 = '0;

    // Reset held with valid asserted
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset", 32'({bz, bsy, dn, rdy}), 32'(4'b0001));
      check("reset_g0", 32'({bz0, bsy0, dn0, rdy0}), 32'(4'b0001));
    end
    rst = 1'b0;

    // Basic tone, accepted on the first edge out of reset
    run_note(0, 10, 2, 0, 0, 0, 0);

    // Rest, then odd period
    nc = 20'd0;  nd = 16'd1; nv = 1'b1;
    run_note(0, 0, 1, 0, 0, 0, 0);
    nc = 20'd7;  nd = 16'd1; nv = 1'b1;
    run_note(0, 7, 1, 0, 0, 0, 0);

    // Back-to-back: second note held valid through the first
    nc = 20'd12; nd = 16'd1; nv = 1'b1;
    run_note(0, 12, 1, 0, 1, 5, 2);
    run_note(0, 5, 2, 0, 0, 0, 0);

    // Zero duration: gap only
    nc = 20'd9;  nd = 16'd0; nv = 1'b1;
    run_note(0, 9, 0, 0, 0, 0, 0);

    // Reset in the middle of PLAY
    nc = 20'd10; nd = 16'd3; nv = 1'b1;
    run_note(0, 10, 3, 49, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("pre_rst_k50", 32'({bz, bsy, dn, rdy}), 32'(model(10, 3, 1, 50)));
    @(posedge clk);
    @(negedge clk);
    check("mid_rst", 32'({bz, bsy, dn, rdy}), 32'(4'b0001));
    rst = 1'b0;
    nc = 20'd8;  nd = 16'd1; nv = 1'b1;
    run_note(0, 8, 1, 0, 0, 0, 0);

    // No-gap instance
    nc0 = 20'd9; nd0 = 16'd0; nv0 = 1'b1;
    run_note(1, 9, 0, 0, 0, 0, 0);
    nc0 = 20'd4; nd0 = 16'd1; nv0 = 1'b1;
    run_note(1, 4, 1, 0, 1, 0, 0);
    run_note(1, 0, 0, 0, 1, 3, 1);
    run_note(1, 3, 1, 0, 0, 0, 0);

    // Randomized note stream on the gapped instance
    c = $urandom_range(0, 30);
    d = $urandom_range(0, 3);
    nc = 20'(c); nd = 16'(d); nv = 1'b1;
    for (int i = 0; i < 12; i++) begin
      c2  = $urandom_range(0, 30);
      d2  = $urandom_range(0, 3);
      b2b = 1'($urandom_range(0, 1));
      run_note(0, c, d, 0, b2b, c2, d2);
      if (!b2b) begin
        nc = 20'(c2); nd = 16'(d2); nv = 1'b1;
      end
      c = c2;
      d = d2;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/music_tone_gen.md
# music_tone_gen

Tone-playback stage that sits directly downstream of the note-to-period lookup. It accepts one note at a time over a valid/ready handshake: a half-period-resolved cycle count plus a duration in milliseconds. It drives a 50 %-duty square wave on the buzzer pin for exactly that duration, then a fixed articulation gap, then pulses `note_done`. The score sequencer upstream issues the next note on `note_done` / `note_ready`.

## Interface
- `CLK_FRE`, 50_000_000: clock frequency in Hz; must be a multiple of 1000.
- `CYCLE_W`, 20: width of the period (cycle count) input.
- `DUR_W`, 16: width of the duration input, in ms.
- `GAP_MS`, 10: silent gap appended after every note, in ms; 0 disables the gap.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `note_valid`  in  1: note fields valid.
- `note_ready`  out  1: block can accept a note; high only in IDLE.
- `note_cycle`  in  CYCLE_W: clocks per tone period; 0 or 1 means rest (silence).
- `note_dur_ms`  in  DUR_W: note length in ms.
- `buzzer`  out  1: square-wave output, registered.
- `busy`  out  1: high in PLAY or GAP.
- `note_done`  out  1: one-cycle pulse when a note (including its gap) completes.

## Operation
- States: IDLE, PLAY, GAP.
- **IDLE**
  - `note_ready`=1.
  - On `note_valid && note_ready`, latch `note_cycle` and `note_dur_ms`, clear the ms prescaler and the period counter.
  - Next state is PLAY, or GAP if `note_dur_ms`=0, or IDLE with `note_done` if both `note_dur_ms`=0 and `GAP_MS`=0.
- **PLAY**
  - Period counter runs 0..cycle-1 and wraps.
  - `buzzer`=1 while counter < cycle>>1, else 0. Odd cycles give a low half that is one clock longer.
  - A latched cycle below 2 gives a rest: `buzzer` held 0 and the counter idle.
  - The ms prescaler counts 0..CLK_FRE/1000-1. Each wrap is one ms tick and decrements the remaining duration.
  - When the last ms tick occurs, go to GAP, or to IDLE if `GAP_MS`=0.
- **GAP**
  - `buzzer`=0.
  - Count `GAP_MS` ms ticks, then go to IDLE.
- **Done:** `note_done` pulses in the cycle the state machine re-enters IDLE. It is never asserted on reset exit.
- **Input handling:** inputs are sampled only on handshake. Changes to `note_cycle` or `note_dur_ms` mid-note are ignored; there is no retrigger or abort.
- **Ready and valid:** `note_valid` while not ready is held off; the upstream holds it. `note_ready` must not depend combinationally on `note_valid`.
- **Counter widths:** remaining-duration counter is DUR_W bits. Prescaler is $clog2(CLK_FRE/1000) bits. Period counter is CYCLE_W bits.

## Timing
- **Reset values:** state IDLE, `buzzer`=0, `busy`=0, `note_done`=0, `note_ready`=1, all counters 0.
- **Start latency:** handshake at edge N. `busy`=1 and `buzzer`=1 (non-rest) from cycle N+1.
- **PLAY length:** exactly `note_dur_ms`·CLK_FRE/1000 cycles.
- **GAP length:** exactly `GAP_MS`·CLK_FRE/1000 cycles.
- **Back-to-back notes:** `note_done`, `note_ready` and IDLE coincide. A note presented in that cycle is accepted, so notes start one idle cycle apart.
- **Reset mid-note:** `rst` takes priority over everything. At the next edge all outputs return to reset values, with no `note_done` pulse.

## Structure
- Package `music_pkg` holds:
  - the state enum (IDLE/PLAY/GAP);
  - the function computing MS_CYC = CLK_FRE/1000;
  - the rest threshold constant (2).
- Sub-module `music_ms_tick`: prescaler with a synchronous clear input and a one-cycle tick output. It is reused by the sequencer.
- Top contains the FSM, duration counter, period counter and output registers.

## Test plan
Run with `CLK_FRE`=100_000 (MS_CYC=100) and `GAP_MS`=1.
1. **Reset:** hold `rst` 3 cycles with `note_valid`=1 -> `buzzer`=0, `busy`=0, `note_ready`=1, no `note_done`.
2. **Basic tone:** `note_cycle`=10, `note_dur_ms`=2 -> 20 periods of 5 high / 5 low starting at N+1, then 100 cycles low, then `note_done` at N+301.
3. **Rest and odd period:**
   - `note_cycle`=0, dur=1 -> `buzzer` stays 0, `note_done` at N+201.
   - `note_cycle`=7 -> 3 high / 4 low.
4. **Back-to-back:** the second note is held valid throughout -> accepted in the `note_done` cycle, second tone starts the next cycle, first note's fields unaffected.
5. **Zero duration:** `note_dur_ms`=0 -> `buzzer` never high, `note_done` at N+101.
   - With `GAP_MS`=0 rebuild -> `note_done` at N+1.
6. **Reset mid-PLAY at cycle N+50** -> outputs return to reset values next edge, no `note_done`; a new note is accepted right after.
